// File: rtl/exec_sequencer.sv
// Execute-stage sequencer for a Y86-64 core: latches one decoded instruction,
// drives the shared ALU for one cycle and holds the result until memory takes it.
module exec_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [1:0]  alu_fun,
  input  logic [63:0] alu_valE,
  input  logic [2:0]  alu_cf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_valE,
  output logic        out_cnd,
  output logic [3:0]  out_icode,
  output logic        out_err,
  output logic [2:0]  cc
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  icode_reg, ifun_reg;
  logic [63:0] val_a_reg, val_b_reg, val_c_reg;
  logic [63:0] out_val_e_reg;
  logic [3:0]  out_icode_reg;
  logic        out_valid_reg, out_cnd_reg, out_err_reg;
  logic [2:0]  cc_reg;
  logic        accept, is_cmov_jmp, is_opq, exec_err, exec_cnd, cond_met, cc_update;
  logic        of_flag, sf_flag, zf_flag;

  assign accept = in_valid & in_ready;
  assign {of_flag, sf_flag, zf_flag} = cc_reg;

  assign is_cmov_jmp = (icode_reg == 4'h2) || (icode_reg == 4'h7);
  assign is_opq      = (icode_reg == 4'h6);
  assign exec_err    = (icode_reg >= 4'hC) ||
                       (is_opq && (ifun_reg > 4'h3)) ||
                       (is_cmov_jmp && (ifun_reg > 4'h6));
  assign cc_update   = is_opq && (ifun_reg <= 4'h3);

  // Condition uses the flags as they stood before this instruction.
  always_comb begin
    cond_met = 1'b0;
    case (ifun_reg)
      4'h0:    cond_met = 1'b1;
      4'h1:    cond_met = (sf_flag ^ of_flag) | zf_flag;
      4'h2:    cond_met = sf_flag ^ of_flag;
      4'h3:    cond_met = zf_flag;
      4'h4:    cond_met = ~zf_flag;
      4'h5:    cond_met = ~(sf_flag ^ of_flag);
      4'h6:    cond_met = ~(sf_flag ^ of_flag) & ~zf_flag;
      default: cond_met = 1'b0;
    endcase
  end
  assign exec_cnd = is_cmov_jmp & cond_met;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    alu_a      = 64'd0;
    alu_b      = 64'd0;
    alu_fun    = 2'b00;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = EXEC;
      end
      EXEC: begin
        state_next = DONE;
        case (icode_reg)
          4'h2, 4'h6:       alu_a = val_a_reg;
          4'h3, 4'h4, 4'h5: alu_a = val_c_reg;
          4'h8, 4'hA:       alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
          4'h9, 4'hB:       alu_a = 64'd8;
          default:          alu_a = 64'd0;
        endcase
        case (icode_reg)
          4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = val_b_reg;
          default:                                  alu_b = 64'd0;
        endcase
        if (is_opq) alu_fun = ifun_reg[1:0];
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? EXEC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icode_reg     <= 4'h0;
      ifun_reg      <= 4'h0;
      val_a_reg     <= 64'd0;
      val_b_reg     <= 64'd0;
      val_c_reg     <= 64'd0;
      out_val_e_reg <= 64'd0;
      out_icode_reg <= 4'h0;
      out_valid_reg <= 1'b0;
      out_cnd_reg   <= 1'b0;
      out_err_reg   <= 1'b0;
      cc_reg        <= 3'b001;
    end else begin
      if (accept) begin
        icode_reg <= icode;
        ifun_reg  <= ifun;
        val_a_reg <= valA;
        val_b_reg <= valB;
        val_c_reg <= valC;
      end
      if (state_reg == EXEC) begin
        out_val_e_reg <= alu_valE;
        out_icode_reg <= icode_reg;
        out_cnd_reg   <= exec_cnd;
        out_err_reg   <= exec_err;
        out_valid_reg <= 1'b1;
        if (cc_update) cc_reg <= alu_cf;
      end else if ((state_reg == DONE) && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_valE  = out_val_e_reg;
  assign out_cnd   = out_cnd_reg;
  assign out_icode = out_icode_reg;
  assign out_err   = out_err_reg;
  assign cc        = cc_reg;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: table of instructions plus back-pressure and
// mid-execute reset sequences; results go through an expected-value queue.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC;
  logic [63:0] alu_a, alu_b, alu_valE;
  logic [1:0]  alu_fun;
  logic [2:0]  alu_cf;
  logic        out_valid, out_ready, out_cnd, out_err;
  logic [63:0] out_valE;
  logic [3:0]  out_icode;
  logic [2:0]  cc;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_valE(alu_valE), .alu_cf(alu_cf),
    .out_valid(out_valid), .out_ready(out_ready), .out_valE(out_valE),
    .out_cnd(out_cnd), .out_icode(out_icode), .out_err(out_err), .cc(cc)
  );

  // Reference ALU: add, sub (B-A), and, xor with {OF,SF,ZF}.
  always_comb begin
    logic of;
    of = 1'b0;
    case (alu_fun)
      2'b00: begin
        alu_valE = alu_a + alu_b;
        of = (alu_a[63] == alu_b[63]) && (alu_valE[63] != alu_a[63]);
      end
      2'b01: begin
        alu_valE = alu_b - alu_a;
        of = (alu_a[63] != alu_b[63]) && (alu_valE[63] != alu_b[63]);
      end
      2'b10:   alu_valE = alu_a & alu_b;
      default: alu_valE = alu_a ^ alu_b;
    endcase
    alu_cf = {of, alu_valE[63], (alu_valE == 64'd0)};
  end

  typedef struct {
    logic [3:0]  ic, fn;
    logic [63:0] a, b, c, e_a, e_b;
    logic [1:0]  e_fun;
    logic [63:0] e_val;
    logic        e_cnd, e_err;
    logic [2:0]  e_cc;
  } vec_t;

  typedef struct {
    logic [63:0] val;
    logic        cnd, err;
    logic [3:0]  ic;
    logic [2:0]  cc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic [3:0] ic, fn, input logic [63:0] a, b, c, ea, eb,
                              input logic [1:0] ef, input logic [63:0] ev,
                              input logic ecnd, eerr, input logic [2:0] ecc);
    vec_t v;
    v.ic = ic; v.fn = fn; v.a = a; v.b = b; v.c = c; v.e_a = ea; v.e_b = eb;
    v.e_fun = ef; v.e_val = ev; v.e_cnd = ecnd; v.e_err = eerr; v.e_cc = ecc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one instruction at the negedge, accept on the next rising edge,
  // then check the ALU drive while in EXEC.
  task automatic issue(input vec_t v, input bit push);
    exp_t e;
    @(negedge clk);
    icode = v.ic; ifun = v.fn; valA = v.a; valB = v.b; valC = v.c;
    in_valid = 1'b1;
    chk("in_ready_offer", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    icode = 4'hF; ifun = 4'hF; valA = '1; valB = '1; valC = '1;
    chk("alu_a", alu_a, v.e_a);
    chk("alu_b", alu_b, v.e_b);
    chk("alu_fun", alu_fun, v.e_fun);
    chk("in_ready_exec", in_ready, 0);
    chk("out_valid_exec", out_valid, 0);
    if (push) begin
      e.val = v.e_val; e.cnd = v.e_cnd; e.err = v.e_err; e.ic = v.ic; e.cc = v.e_cc;
      sb.push_back(e);
    end
  endtask

  task automatic collect();
    exp_t e;
    chk("latency_out_valid", out_valid, 1);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: got result %h expected none", out_valE);
    end else begin
      e = sb.pop_front();
      chk("out_valE", out_valE, e.val);
      chk("out_cnd", out_cnd, e.cnd);
      chk("out_icode", out_icode, e.ic);
      chk("out_err", out_err, e.err);
      chk("cc", cc, e.cc);
      $display("txn icode=%h valE=%h cnd=%0d err=%0d cc=%b", out_icode, out_valE,
               out_cnd, out_err, cc);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    icode = 4'h0; ifun = 4'h0; valA = '0; valB = '0; valC = '0;

    tbl.push_back(mk(4'h6, 4'h1, 5, 5, 0, 5, 5, 2'd1, 0, 0, 0, 3'b001));
    tbl.push_back(mk(4'h6, 4'h1, 5, 3, 0, 5, 3, 2'd1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 3'b010));
    tbl.push_back(mk(4'h7, 4'h2, 11, 22, 33, 0, 0, 2'd0, 0, 1, 0, 3'b010));
    tbl.push_back(mk(4'h7, 4'h5, 11, 22, 33, 0, 0, 2'd0, 0, 0, 0, 3'b010));
    tbl.push_back(mk(4'h2, 4'h0, 64'h1234, 64'h77, 0, 64'h1234, 0, 2'd0, 64'h1234, 1, 0, 3'b010));
    tbl.push_back(mk(4'h2, 4'h1, 7, 0, 0, 7, 0, 2'd0, 7, 1, 0, 3'b010));
    tbl.push_back(mk(4'h2, 4'h3, 9, 0, 0, 9, 0, 2'd0, 9, 0, 0, 3'b010));
    tbl.push_back(mk(4'h7, 4'h4, 0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 3'b010));
    tbl.push_back(mk(4'h7, 4'h6, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 3'b010));
    tbl.push_back(mk(4'hA, 4'h0, 0, 64'h100, 0, NEG8, 64'h100, 2'd0, 64'hF8, 0, 0, 3'b010));
    tbl.push_back(mk(4'h8, 4'h0, 0, 64'h200, 0, NEG8, 64'h200, 2'd0, 64'h1F8, 0, 0, 3'b010));
    tbl.push_back(mk(4'h9, 4'h0, 0, 64'h300, 0, 8, 64'h300, 2'd0, 64'h308, 0, 0, 3'b010));
    tbl.push_back(mk(4'hB, 4'h0, 0, 64'h10, 0, 8, 64'h10, 2'd0, 64'h18, 0, 0, 3'b010));
    tbl.push_back(mk(4'h3, 4'h0, 0, 64'h99, 64'h55, 64'h55, 0, 2'd0, 64'h55, 0, 0, 3'b010));
    tbl.push_back(mk(4'h4, 4'h0, 0, 64'h20, 64'h10, 64'h10, 64'h20, 2'd0, 64'h30, 0, 0, 3'b010));
    tbl.push_back(mk(4'h5, 4'h0, 0, 8, 8, 8, 8, 2'd0, 64'h10, 0, 0, 3'b010));
    tbl.push_back(mk(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 2'd0,
                     64'h8000_0000_0000_0000, 0, 0, 3'b110));
    tbl.push_back(mk(4'h7, 4'h2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 3'b110));
    tbl.push_back(mk(4'h7, 4'h5, 0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 3'b110));
    tbl.push_back(mk(4'h6, 4'h2, 64'hF0, 64'h0F, 0, 64'hF0, 64'h0F, 2'd2, 0, 0, 0, 3'b001));
    tbl.push_back(mk(4'h6, 4'h3, 64'hFF, 64'h0F, 0, 64'hFF, 64'h0F, 2'd3, 64'hF0, 0, 0, 3'b000));
    tbl.push_back(mk(4'hE, 4'h0, 3, 4, 5, 0, 0, 2'd0, 0, 0, 1, 3'b000));
    tbl.push_back(mk(4'h6, 4'h7, 1, 1, 0, 1, 1, 2'd3, 0, 0, 1, 3'b000));
    tbl.push_back(mk(4'h7, 4'h7, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 3'b000));
    tbl.push_back(mk(4'h2, 4'h6, 64'h42, 0, 0, 64'h42, 0, 2'd0, 64'h42, 1, 0, 3'b000));
    tbl.push_back(mk(4'h1, 4'h0, 1, 2, 3, 0, 0, 2'd0, 0, 0, 0, 3'b000));

    // Reset values, held while rst_n is low.
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cc", cc, 3'b001);
    chk("rst_out_valE", out_valE, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i], 1'b1);
      @(posedge clk); #1;
      collect();
      @(posedge clk); #1;
      chk("out_valid_drop", out_valid, 0);
    end

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(mk(4'h6, 4'h0, 2, 3, 0, 2, 3, 2'd0, 5, 0, 0, 3'b000), 1'b1);
    @(posedge clk); #1;
    collect();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_valE", out_valE, 5);
      chk("hold_out_icode", out_icode, 4'h6);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    issue(mk(4'h6, 4'h1, 3, 5, 0, 3, 5, 2'd1, 2, 0, 0, 3'b000), 1'b1);
    @(posedge clk); #1;
    collect();

    // Reset in the middle of EXEC: nothing from the aborted op may land.
    @(posedge clk); #1;
    issue(mk(4'h6, 4'h1, 5, 3, 0, 5, 3, 2'd1, 0, 0, 0, 3'b000), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_cc", cc, 3'b001);
    chk("abort_out_valE", out_valE, 0);
    chk("abort_out_icode", out_icode, 0);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    chk("release_cc", cc, 3'b001);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
